tx_cell_queue: RTL and testbench
================================

# tx_cell_queue

Per-port egress cell buffer between the cell-forwarding FSM and a Utopia Level 1 transmit PHY. It accepts whole 53-byte ATM cells (HEC already rewritten) through a valid/ready handshake and stores up to `Depth` cells in a circular queue. It serialises them byte-by-byte onto a Utopia-1 transmit bus, gated by the PHY's cell-available flag. One instance per Tx port.

## Interface
- `Depth`, 4: queue capacity in cells; power of two, ≥ 2.
- `CntWidth`, 16: width of the transmitted-cell counter.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream presents a cell.
- `in_ready`  out  1  queue can accept a cell this cycle.
- `in_cell`  in  424  cell; byte 0 (first header byte) in [423:416], byte 52 in [7:0].
- `tx_data`  out  8  Utopia transmit byte.
- `tx_soc`  out  1  start-of-cell; high with byte 0 only.
- `tx_en_n`  out  1  active-low transmit enable; low on every valid byte.
- `tx_clav`  in  1  PHY can accept one full cell.
- `occupancy`  out  $clog2(Depth)+1  cells currently stored.
- `cells_sent`  out  CntWidth  saturating count of fully transmitted cells.

## Operation
- Reset values: `in_ready`=1, `tx_data`=0, `tx_soc`=0, `tx_en_n`=1, `occupancy`=0, `cells_sent`=0. Pointers are 0, the FSM is in IDLE, and stored data is discarded.
- Storage: `Depth` × 424-bit array, write pointer, read pointer, count. Pointers wrap modulo `Depth`.
- Push: occurs when `in_valid && in_ready`. The cell is written at the write pointer and the write pointer increments.
- `in_ready` = (count < `Depth`), decoded from the registered count. There is no combinational path from `tx_clav` or pop to `in_ready`.
- Pop: the head cell is loaded into a 424-bit output register, the read pointer increments and count decrements.
- Push and pop in the same cycle leave count unchanged. A pop at count = `Depth` does not admit a push in that same cycle.
- FSM states: IDLE and SEND, plus a 6-bit byte index 0..52.
  - IDLE: if count > 0 and `tx_clav`=1, pop, set index to 0 and go to SEND. Otherwise hold idle outputs.
  - SEND: drive byte[index] of the output register, with `tx_en_n`=0 and `tx_soc`=(index==0). Index increments each cycle.
  - At index 52: if count > 0 and `tx_clav`=1, pop, set index to 0 and stay in SEND (back-to-back cell, no gap). Otherwise go to IDLE.
- `tx_clav` is sampled only at cell start decisions. Deassertion mid-cell is ignored and the cell completes all 53 bytes.
- `cells_sent` increments on the cycle byte 52 is driven and saturates at all-ones.
- All Utopia outputs are registered. In IDLE: `tx_en_n`=1, `tx_soc`=0, `tx_data`=0.

## Timing
- Push sampled at edge E0 → `occupancy` = 1 after E0. If `tx_clav`=1 at E1, byte 0 is driven with `tx_soc`=1 after E1. Minimum latency from push to first byte is 2 cycles.
- Each cell takes exactly 53 consecutive cycles of `tx_en_n`=0.
- Back-to-back cells: byte 52 of cell N is followed immediately by byte 0 of cell N+1.
- `occupancy` decrements on the edge that drives byte 0 of the popped cell.
- Full queue: `in_ready`=0 while count = `Depth`. It returns to 1 the cycle after a pop.
- `rst` asserted mid-cell: outputs go to reset values immediately (asynchronously). The partial cell and all queued cells are lost, and `cells_sent` clears.

## Test plan
- Single cell, `tx_clav`=1: push bytes 0x00..0x34 → after 2 cycles, 53 bytes 0x00..0x34 appear, `tx_soc` is high only on 0x00, `cells_sent`=1, `occupancy` returns to 0.
- Fill: `tx_clav`=0, push 5 cells with `Depth`=4 → 4 accepted, `in_ready`=0, `occupancy`=4. Raise `tx_clav` → cells exit in push order, and `in_ready`=1 the cycle after the first pop.
- Back-to-back: 3 cells queued, `tx_clav`=1 held → 159 contiguous `tx_en_n`=0 cycles, `tx_soc` pulses at offsets 0, 53 and 106.
- Clav gating: `tx_clav` drops at byte 10 of cell 1 with cell 2 queued → cell 1 completes all 53 bytes, then 1+ idle cycles until `tx_clav`=1, then cell 2 starts.
- Simultaneous push/pop at `occupancy`=2 → `occupancy` stays 2. Wrap the pointers over 10 cells and check data integrity.
- Reset at byte 20 with 2 cells queued → `tx_en_n`=1 immediately and all outputs take reset values. After release, no bytes are sent until a new push.

Source files
------------

// File: rtl/tx_cell_queue.sv
// Per-port egress cell queue: buffers whole 53-byte ATM cells and serialises
// them onto a Utopia-1 transmit bus, starting a cell only when the PHY asserts clav.
module tx_cell_queue #(
  parameter int Depth    = 4,
  parameter int CntWidth = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [423:0]              in_cell,
  output logic [7:0]                tx_data,
  output logic                      tx_soc,
  output logic                      tx_en_n,
  input  logic                      tx_clav,
  output logic [$clog2(Depth):0]    occupancy,
  output logic [CntWidth-1:0]       cells_sent
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam logic [5:0] LastIdx = 6'd52;

  typedef enum logic {IDLE, SEND} state_e;

  logic [423:0]          mem_q [Depth];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  state_e                state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [423:0]          shreg_q, shreg_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_soc_q, tx_soc_d;
  logic                  tx_en_n_q, tx_en_n_d;
  logic [CntWidth-1:0]   sent_q, sent_d;

  logic         push, pop, start, start_ok;
  logic [423:0] head;

  // in_ready depends only on the registered count, never on this cycle's pop.
  assign in_ready = (count_q < CW'(Depth));
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];
  assign start_ok = (count_q != '0) && tx_clav;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    tx_data_d = 8'h00;
    tx_soc_d  = 1'b0;
    tx_en_n_d = 1'b1;
    sent_d    = sent_q;
    start     = 1'b0;
    unique case (state_q)
      IDLE: start = start_ok;
      SEND: begin
        if (idx_q == LastIdx) begin
          start = start_ok;
          if (!start_ok) state_d = IDLE;
        end else begin
          idx_d     = idx_q + 6'd1;
          tx_data_d = shreg_q[423:416];
          shreg_d   = {shreg_q[415:0], 8'h00};
          tx_en_n_d = 1'b0;
          if (idx_q == LastIdx - 6'd1 && sent_q != '1) sent_d = sent_q + CntWidth'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Cell start: byte 0 leaves straight from the queue head, the rest from the shifter.
    if (start) begin
      state_d   = SEND;
      idx_d     = 6'd0;
      tx_data_d = head[423:416];
      shreg_d   = {head[415:0], 8'h00};
      tx_soc_d  = 1'b1;
      tx_en_n_d = 1'b0;
    end
  end

  assign pop = start;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_cell;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      shreg_q   <= '0;
      tx_data_q <= 8'h00;
      tx_soc_q  <= 1'b0;
      tx_en_n_q <= 1'b1;
      sent_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      tx_data_q <= tx_data_d;
      tx_soc_q  <= tx_soc_d;
      tx_en_n_q <= tx_en_n_d;
      sent_q    <= sent_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_soc     = tx_soc_q;
  assign tx_en_n    = tx_en_n_q;
  assign occupancy  = count_q;
  assign cells_sent = sent_q;

endmodule

// File: tb/tb_tx_cell_queue.sv
// Directed bench for tx_cell_queue: each task drives one scenario and checks
// hand-computed Utopia bytes, handshake and counters inline.
module tb_tx_cell_queue;
  logic         clk = 1'b0;
  logic         rst, in_valid, tx_clav;
  logic [423:0] in_cell;
  logic         in_ready, tx_soc, tx_en_n;
  logic [7:0]   tx_data;
  logic [2:0]   occupancy;
  logic [15:0]  cells_sent;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tx_cell_queue #(.Depth(4), .CntWidth(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cell(in_cell),
    .tx_data(tx_data), .tx_soc(tx_soc), .tx_en_n(tx_en_n), .tx_clav(tx_clav),
    .occupancy(occupancy), .cells_sent(cells_sent)
  );

  // Cell whose byte i is base+i.
  function automatic logic [423:0] mk_cell(input logic [7:0] base);
    logic [423:0] c;
    c = '0;
    for (int i = 0; i < 53; i++) c[423-8*i -: 8] = base + 8'(i);
    return c;
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; tx_clav = 1'b0; in_cell = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_cell(input logic [7:0] base);
    in_valid = 1'b1; in_cell = mk_cell(base);
    step;
    in_valid = 1'b0;
  endtask

  task automatic wait_soc(input int maxc, output bit to);
    int n;
    n = 0;
    while (tx_soc !== 1'b1 && n < maxc) begin step; n++; end
    to = (tx_soc !== 1'b1);
  endtask

  // Collects 53 bytes starting at the current (byte 0) cycle; ends on byte 52.
  task automatic grab_cell(output logic [423:0] got, output int errs);
    errs = 0; got = '0;
    for (int i = 0; i < 53; i++) begin
      got[423-8*i -: 8] = tx_data;
      if (tx_en_n !== 1'b0) errs++;
      if (tx_soc !== (i == 0)) errs++;
      if (i < 52) step;
    end
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    total++; if (tx_soc !== 1'b0) begin bad++; $display("FAIL rst_tx_soc got=%b exp=0", tx_soc); end
    total++; if (tx_en_n !== 1'b1) begin bad++; $display("FAIL rst_tx_en_n got=%b exp=1", tx_en_n); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    total++; if (cells_sent !== 16'd0) begin bad++; $display("FAIL rst_sent got=%0d exp=0", cells_sent); end
  endtask

  task automatic test_single;
    logic [423:0] got; int errs;
    do_reset;
    tx_clav = 1'b1;
    push_cell(8'h00);
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL single_occ1 got=%0d exp=1", occupancy); end
    total++; if (tx_en_n !== 1'b1) begin bad++; $display("FAIL single_early got=%b exp=1", tx_en_n); end
    step;
    total++; if (tx_soc !== 1'b1 || tx_data !== 8'h00) begin bad++; $display("FAIL single_first soc=%b data=%h exp soc=1 data=00", tx_soc, tx_data); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL single_occ0 got=%0d exp=0", occupancy); end
    grab_cell(got, errs);
    total++; if (got !== mk_cell(8'h00)) begin bad++; $display("FAIL single_data got=%h exp=%h", got, mk_cell(8'h00)); end
    total++; if (errs !== 0) begin bad++; $display("FAIL single_framing got=%0d exp=0", errs); end
    total++; if (cells_sent !== 16'd1) begin bad++; $display("FAIL single_sent got=%0d exp=1", cells_sent); end
    step;
    total++; if (tx_en_n !== 1'b1 || tx_data !== 8'h00) begin bad++; $display("FAIL single_idle en_n=%b data=%h exp 1/00", tx_en_n, tx_data); end
  endtask

  task automatic test_fill;
    logic [7:0] fb [4] = '{8'h10, 8'h40, 8'h70, 8'hA0};
    logic [423:0] got; int errs;
    do_reset;
    for (int k = 0; k < 4; k++) push_cell(fb[k]);
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_occ got=%0d exp=4", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", in_ready); end
    push_cell(8'hD0);
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_reject got=%0d exp=4", occupancy); end
    tx_clav = 1'b1;
    step;
    total++; if (tx_soc !== 1'b1) begin bad++; $display("FAIL fill_start got=%b exp=1", tx_soc); end
    total++; if (occupancy !== 3'd3 || in_ready !== 1'b1) begin bad++; $display("FAIL fill_pop occ=%0d ready=%b exp 3/1", occupancy, in_ready); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        step;
        total++; if (tx_soc !== 1'b1) begin bad++; $display("FAIL fill_b2b%0d got=%b exp=1", k, tx_soc); end
      end
      grab_cell(got, errs);
      total++; if (got !== mk_cell(fb[k]) || errs !== 0) begin bad++; $display("FAIL fill_cell%0d got=%h errs=%0d exp=%h", k, got, errs, mk_cell(fb[k])); end
    end
    step;
    total++; if (tx_en_n !== 1'b1 || cells_sent !== 16'd4) begin bad++; $display("FAIL fill_end en_n=%b sent=%0d exp 1/4", tx_en_n, cells_sent); end
  endtask

  task automatic test_back_to_back;
    int soc_at [3]; int soc_n, en_errs; bit to;
    do_reset;
    push_cell(8'h01); push_cell(8'h55); push_cell(8'hAA);
    tx_clav = 1'b1;
    wait_soc(10, to);
    total++; if (to) begin bad++; $display("FAIL b2b_timeout got=no_soc exp=soc"); end
    soc_n = 0; en_errs = 0; soc_at = '{-1, -1, -1};
    for (int c = 0; c < 159; c++) begin
      if (tx_en_n !== 1'b0) en_errs++;
      if (tx_soc === 1'b1) begin
        if (soc_n < 3) soc_at[soc_n] = c;
        soc_n++;
      end
      step;
    end
    total++; if (en_errs !== 0) begin bad++; $display("FAIL b2b_gap got=%0d exp=0", en_errs); end
    total++; if (soc_n !== 3) begin bad++; $display("FAIL b2b_soc_count got=%0d exp=3", soc_n); end
    total++; if (soc_at[0] !== 0 || soc_at[1] !== 53 || soc_at[2] !== 106) begin bad++; $display("FAIL b2b_soc_pos got=%0d,%0d,%0d exp=0,53,106", soc_at[0], soc_at[1], soc_at[2]); end
    total++; if (tx_en_n !== 1'b1 || cells_sent !== 16'd3) begin bad++; $display("FAIL b2b_end en_n=%b sent=%0d exp 1/3", tx_en_n, cells_sent); end
  endtask

  task automatic test_clav_gating;
    logic [423:0] got; int errs, ierr; bit to;
    do_reset;
    push_cell(8'h20); push_cell(8'h90);
    tx_clav = 1'b1;
    wait_soc(10, to);
    total++; if (to) begin bad++; $display("FAIL clav_timeout got=no_soc exp=soc"); end
    repeat (10) step;
    total++; if (tx_data !== 8'h2A) begin bad++; $display("FAIL clav_byte10 got=%h exp=2a", tx_data); end
    tx_clav = 1'b0;
    repeat (42) step;
    total++; if (tx_data !== 8'h54 || tx_en_n !== 1'b0) begin bad++; $display("FAIL clav_byte52 data=%h en_n=%b exp 54/0", tx_data, tx_en_n); end
    total++; if (cells_sent !== 16'd1) begin bad++; $display("FAIL clav_sent got=%0d exp=1", cells_sent); end
    step;
    ierr = 0;
    for (int c = 0; c < 5; c++) begin
      if (tx_en_n !== 1'b1) ierr++;
      step;
    end
    total++; if (ierr !== 0 || occupancy !== 3'd1) begin bad++; $display("FAIL clav_hold errs=%0d occ=%0d exp 0/1", ierr, occupancy); end
    tx_clav = 1'b1;
    step;
    total++; if (tx_soc !== 1'b1 || tx_data !== 8'h90) begin bad++; $display("FAIL clav_resume soc=%b data=%h exp 1/90", tx_soc, tx_data); end
    grab_cell(got, errs);
    total++; if (got !== mk_cell(8'h90) || errs !== 0) begin bad++; $display("FAIL clav_cell2 got=%h errs=%0d exp=%h", got, errs, mk_cell(8'h90)); end
  endtask

  task automatic test_simul_pushpop;
    logic [7:0] sb [3] = '{8'h30, 8'h60, 8'hC0};
    logic [423:0] got; int errs;
    do_reset;
    push_cell(sb[0]); push_cell(sb[1]);
    tx_clav = 1'b1;
    push_cell(sb[2]);
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL simul_occ got=%0d exp=2", occupancy); end
    total++; if (tx_soc !== 1'b1) begin bad++; $display("FAIL simul_start got=%b exp=1", tx_soc); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step;
      grab_cell(got, errs);
      total++; if (got !== mk_cell(sb[k]) || errs !== 0) begin bad++; $display("FAIL simul_cell%0d got=%h errs=%0d exp=%h", k, got, errs, mk_cell(sb[k])); end
    end
  endtask

  task automatic test_wrap;
    logic [423:0] got; logic [7:0] base; int errs; bit to;
    do_reset;
    tx_clav = 1'b1;
    for (int k = 0; k < 10; k++) begin
      base = 8'(k * 23 + 5);
      push_cell(base);
      wait_soc(5, to);
      total++; if (to) begin bad++; $display("FAIL wrap_timeout%0d got=no_soc exp=soc", k); end
      grab_cell(got, errs);
      total++; if (got !== mk_cell(base) || errs !== 0) begin bad++; $display("FAIL wrap_cell%0d got=%h errs=%0d exp=%h", k, got, errs, mk_cell(base)); end
      step;
    end
    total++; if (cells_sent !== 16'd10) begin bad++; $display("FAIL wrap_sent got=%0d exp=10", cells_sent); end
  endtask

  task automatic test_reset_mid;
    logic [423:0] got; int errs, ierr; bit to;
    do_reset;
    push_cell(8'h11); push_cell(8'h22); push_cell(8'h33);
    tx_clav = 1'b1;
    wait_soc(10, to);
    total++; if (to) begin bad++; $display("FAIL rmid_timeout got=no_soc exp=soc"); end
    repeat (20) step;
    total++; if (tx_data !== 8'h25 || occupancy !== 3'd2) begin bad++; $display("FAIL rmid_pre data=%h occ=%0d exp 25/2", tx_data, occupancy); end
    #2 rst = 1'b1;
    #1;
    total++; if (tx_en_n !== 1'b1 || tx_soc !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL rmid_tx en_n=%b soc=%b data=%h exp 1/0/00", tx_en_n, tx_soc, tx_data); end
    total++; if (occupancy !== 3'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rmid_queue occ=%0d ready=%b exp 0/1", occupancy, in_ready); end
    @(posedge clk); #1 rst = 1'b0;
    ierr = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx_en_n !== 1'b1) ierr++;
      step;
    end
    total++; if (ierr !== 0 || occupancy !== 3'd0) begin bad++; $display("FAIL rmid_silent errs=%0d occ=%0d exp 0/0", ierr, occupancy); end
    push_cell(8'h77);
    wait_soc(5, to);
    grab_cell(got, errs);
    total++; if (to || got !== mk_cell(8'h77) || errs !== 0) begin bad++; $display("FAIL rmid_after got=%h errs=%0d exp=%h", got, errs, mk_cell(8'h77)); end
    total++; if (cells_sent !== 16'd1) begin bad++; $display("FAIL rmid_sent got=%0d exp=1", cells_sent); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; tx_clav = 1'b0; in_cell = '0;
    test_reset;
    test_single;
    test_fill;
    test_back_to_back;
    test_clav_gating;
    test_simul_pushpop;
    test_wrap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
